// File: rtl/key_debouncer.sv
// Debounces active-low push-buttons into active-high levels with one-cycle press/release strobes.
// Each key is synchronised by two flops and must hold a new level for DEBOUNCE_CYCLES samples.
module key_debouncer #(
  parameter int NUM_KEYS        = 3,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_n_raw,
  output logic [NUM_KEYS-1:0] key_debounced,
  output logic [NUM_KEYS-1:0] key_pressed,
  output logic [NUM_KEYS-1:0] key_released
);

  typedef enum logic {
    RELEASED = 1'b0,
    PRESSED  = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_KEYS-1:0] s1_q, s2_q, sample;
  logic [NUM_KEYS-1:0] pressed_q, pressed_d, released_q, released_d;
  state_e              state_q [NUM_KEYS];
  state_e              state_d [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_q   [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_d   [NUM_KEYS];

  // Synchroniser resets to the released level so a held key is seen as a fresh press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '1;
      s2_q <= '1;
    end else begin
      s1_q <= key_n_raw;
      s2_q <= s1_q;
    end
  end

  assign sample = ~s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        state_q[i] <= RELEASED;
        cnt_q[i]   <= '0;
      end
      pressed_q  <= '0;
      released_q <= '0;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      pressed_q  <= pressed_d;
      released_q <= released_d;
    end
  end

  always_comb begin
    pressed_d  = '0;
    released_d = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = '0;
      if (state_e'(sample[i]) != state_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          state_d[i]    = state_e'(sample[i]);
          pressed_d[i]  = sample[i];
          released_d[i] = ~sample[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    key_debounced = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      key_debounced[i] = (state_q[i] == PRESSED);
    end
  end

  assign key_pressed  = pressed_q;
  assign key_released = released_q;

endmodule

// File: tb/tb_key_debouncer.sv
// Bench for key_debouncer: directed scenarios plus randomized key activity against a window-based model.
module tb_key_debouncer;

  localparam int NK = 3;
  localparam int DC = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NK-1:0] key_n_raw = '0;
  logic [NK-1:0] key_debounced, key_pressed, key_released;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  key_debouncer #(.NUM_KEYS(NK), .DEBOUNCE_CYCLES(DC), .CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_n_raw    (key_n_raw),
    .key_debounced(key_debounced),
    .key_pressed  (key_pressed),
    .key_released (key_released)
  );

  always #5 clk = ~clk;

  // Model: a key flips once its last DC synchronised samples all disagree with its level.
  logic [NK-1:0] m_s1 = '1, m_s2 = '1, m_deb = '0, m_pr = '0, m_rl = '0;
  logic [DC-1:0] m_win [NK] = '{default: '0};

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_s1 = '1; m_s2 = '1; m_deb = '0; m_pr = '0; m_rl = '0;
      for (int k = 0; k < NK; k++) m_win[k] = '0;
    end else begin
      for (int k = 0; k < NK; k++) begin
        logic samp;
        samp     = ~m_s2[k];
        m_win[k] = {m_win[k][DC-2:0], samp};
        m_pr[k]  = 1'b0;
        m_rl[k]  = 1'b0;
        if (m_win[k] == {DC{~m_deb[k]}}) begin
          m_deb[k] = samp;
          m_pr[k]  = samp;
          m_rl[k]  = ~samp;
        end
      end
      m_s2 = m_s1;
      m_s1 = key_n_raw;
    end
  end

  task automatic check(input string nm, input logic [NK-1:0] act, input logic [NK-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("cyc_debounced", key_debounced, m_deb);
      check("cyc_pressed",   key_pressed,   m_pr);
      check("cyc_released",  key_released,  m_rl);
    end
  end

  // Pins both the DUT and the model to hand-derived values.
  task automatic lit(input string nm, input logic [NK-1:0] d, input logic [NK-1:0] p,
                     input logic [NK-1:0] r);
    check({nm, "_deb"}, key_debounced, d);
    check({nm, "_pr"},  key_pressed,   p);
    check({nm, "_rl"},  key_released,  r);
    check({nm, "_mdeb"}, m_deb, d);
    check({nm, "_mpr"},  m_pr,  p);
    check({nm, "_mrl"},  m_rl,  r);
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [NK-1:0] v);
    @(negedge clk);
    key_n_raw = v;
  endtask

  initial begin
    int hold [NK];
    edges(3);
    chk_en = 1'b1;
    lit("reset", 3'b000, 3'b000, 3'b000);

    // Clean press of KEY2, raw level applied together with reset release.
    @(negedge clk);
    key_n_raw = 3'b011;
    rst_n     = 1'b1;
    edges(5); lit("press_e5", 3'b000, 3'b000, 3'b000);
    edges(1); lit("press_e6", 3'b100, 3'b100, 3'b000);
    edges(1); lit("press_e7", 3'b100, 3'b000, 3'b000);

    // KEY1 bounces in 2-cycle runs, never long enough to register.
    for (int c = 0; c < 12; c++) drive({1'b0, ((c / 2) % 2 == 1), 1'b1});
    drive(3'b001);
    edges(5); lit("bounce_e5", 3'b100, 3'b000, 3'b000);
    edges(1); lit("bounce_e6", 3'b110, 3'b010, 3'b000);

    drive(3'b101);
    edges(5); lit("release_e5", 3'b110, 3'b000, 3'b000);
    edges(1); lit("release_e6", 3'b010, 3'b000, 3'b100);

    drive(3'b111);
    edges(8); lit("idle", 3'b000, 3'b000, 3'b000);
    drive(3'b000);
    edges(5); lit("simul_e5", 3'b000, 3'b000, 3'b000);
    edges(1); lit("simul_e6", 3'b111, 3'b111, 3'b000);

    // Reset asserted mid-cycle while all keys are debounced-pressed.
    edges(1);
    #1 rst_n = 1'b0;
    #1 lit("async_rst", 3'b000, 3'b000, 3'b000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    edges(5); lit("held_rst_e5", 3'b000, 3'b000, 3'b000);
    edges(1); lit("held_rst_e6", 3'b111, 3'b111, 3'b000);

    // Reset after two mismatch samples have been counted.
    drive(3'b111);
    edges(8);
    drive(3'b000);
    edges(4);
    #2 rst_n = 1'b0;
    #1 lit("midcnt_rst", 3'b000, 3'b000, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    edges(5); lit("midcnt_e5", 3'b000, 3'b000, 3'b000);
    edges(1); lit("midcnt_e6", 3'b111, 3'b111, 3'b000);

    for (int k = 0; k < NK; k++) hold[k] = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 599) != 0);
      for (int k = 0; k < NK; k++) begin
        if (hold[k] == 0) begin
          key_n_raw[k] = 1'($urandom_range(0, 1));
          hold[k]      = int'($urandom_range(0, 9));
        end else begin
          hold[k]--;
        end
      end
    end
    rst_n = 1'b1;
    edges(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
